// File: rtl/uop_stream_ctrl_if.sv
// uop_stream_ctrl_if: operand-in and result-out ready/valid streams of uop_stream_ctrl.
// master = producer/consumer side, slave = the controller.
interface uop_stream_ctrl_if #(
  parameter int unsigned W = 32
) ();
  localparam int unsigned SW = $clog2(W);

  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_src;
  logic [SW-1:0] in_shamt;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;

  modport master (
    output in_valid, in_src, in_shamt, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_src, in_shamt, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/uop_stream_ctrl.sv
// uop_stream_ctrl: credit-based ready/valid shell around a fixed-latency uop_block.
// Define UOP_STREAM_STATS_EN to add the stat_issued / stat_stall counters.
module uop_stream_ctrl #(
  parameter int unsigned W       = 32,
  parameter int unsigned LATENCY = 1,
  parameter int unsigned DEPTH   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  uop_stream_ctrl_if.slave           s,
  output logic [W-1:0]               blk_src,
  output logic [$clog2(W)-1:0]       blk_shamt,
  input  logic [W-1:0]               blk_dst,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
`ifdef UOP_STREAM_STATS_EN
  ,
  output logic [31:0]                stat_issued,
  output logic [31:0]                stat_stall
`endif
);
  localparam int unsigned OW = $clog2(DEPTH+1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [OW-1:0] DEPTH_O = OW'(DEPTH);
  localparam logic [PW-1:0] LAST_P  = PW'(DEPTH-1);

  logic          fire_in;
  logic          fire_out;
  logic          push;
  logic          empty;
  logic          full;
  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [OW-1:0] count;

  assign blk_src   = s.in_src;
  assign blk_shamt = s.in_shamt;

  // Credits come from registered occupancy only: no out_ready -> in_ready path.
  assign s.in_ready = !rst && (occupancy < DEPTH_O);
  assign fire_in    = s.in_valid & s.in_ready;

  assign empty      = (count == '0);
  assign full       = (count == DEPTH_O);
  assign s.out_valid = !empty;
  assign s.out_data  = mem[rd_ptr];
  assign fire_out    = s.out_valid & s.out_ready;

  generate
    if (LATENCY == 0) begin : g_nopipe
      assign push = fire_in;
    end else begin : g_pipe
      logic [LATENCY-1:0] vpipe;

      always_ff @(posedge clk) begin
        if (rst) begin
          vpipe <= '0;
        end else begin
          vpipe[0] <= fire_in;
          for (int unsigned k = 1; k < LATENCY; k++) begin
            vpipe[k] <= vpipe[k-1];
          end
        end
      end

      assign push = vpipe[LATENCY-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      occupancy <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == LAST_P) ? '0 : wr_ptr + 1'b1;
      end
      if (fire_out) begin
        rd_ptr <= (rd_ptr == LAST_P) ? '0 : rd_ptr + 1'b1;
      end

      case ({push, fire_out})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      case ({fire_in, fire_out})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[wr_ptr] <= blk_dst;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full && !fire_out));

`ifdef UOP_STREAM_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_issued <= '0;
      stat_stall  <= '0;
    end else begin
      if (fire_in && (stat_issued != '1)) begin
        stat_issued <= stat_issued + 1'b1;
      end
      if (s.in_valid && !s.in_ready && (stat_stall != '1)) begin
        stat_stall <= stat_stall + 1'b1;
      end
    end
  end
`endif
endmodule

// File: tb/tb_uop_stream_ctrl.sv
// tb_uop_stream_ctrl: directed self-checking bench; each DUT instance is wrapped around a
// rotate-left uop_block model with the matching register latency.
module tb_uop_stream_ctrl;
  logic clk;
  logic rst;
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] rotl(input logic [31:0] v, input logic [4:0] sh);
    return (v << sh) | (v >> (6'd32 - {1'b0, sh}));
  endfunction

  // A: LATENCY=1 DEPTH=4
  uop_stream_ctrl_if #(.W(32)) a_if ();
  logic [31:0] a_bsrc, a_bdst;
  logic [4:0]  a_bsh;
  logic [2:0]  a_occ;
  // B: LATENCY=2 DEPTH=4
  uop_stream_ctrl_if #(.W(32)) b_if ();
  logic [31:0] b_bsrc, b_bdst, b_r1;
  logic [4:0]  b_bsh;
  logic [2:0]  b_occ;
  // C: LATENCY=0 DEPTH=1
  uop_stream_ctrl_if #(.W(32)) c_if ();
  logic [31:0] c_bsrc, c_bdst;
  logic [4:0]  c_bsh;
  logic [0:0]  c_occ;
  // D: LATENCY=1 DEPTH=3
  uop_stream_ctrl_if #(.W(32)) d_if ();
  logic [31:0] d_bsrc, d_bdst;
  logic [4:0]  d_bsh;
  logic [1:0]  d_occ;
  // E: LATENCY=3 DEPTH=4
  uop_stream_ctrl_if #(.W(32)) e_if ();
  logic [31:0] e_bsrc, e_bdst, e_r1, e_r2;
  logic [4:0]  e_bsh;
  logic [2:0]  e_occ;
  // F: LATENCY=1 DEPTH=2
  uop_stream_ctrl_if #(.W(32)) f_if ();
  logic [31:0] f_bsrc, f_bdst;
  logic [4:0]  f_bsh;
  logic [1:0]  f_occ;
`ifdef UOP_STREAM_STATS_EN
  logic [31:0] a_si, a_ss, b_si, b_ss, c_si, c_ss, d_si, d_ss, e_si, e_ss, f_si, f_ss;
`endif

  always @(posedge clk) a_bdst <= rotl(a_bsrc, a_bsh);
  always @(posedge clk) begin b_r1 <= rotl(b_bsrc, b_bsh); b_bdst <= b_r1; end
  assign c_bdst = rotl(c_bsrc, c_bsh);
  always @(posedge clk) d_bdst <= rotl(d_bsrc, d_bsh);
  always @(posedge clk) begin e_r1 <= rotl(e_bsrc, e_bsh); e_r2 <= e_r1; e_bdst <= e_r2; end
  always @(posedge clk) f_bdst <= rotl(f_bsrc, f_bsh);

  uop_stream_ctrl #(.W(32), .LATENCY(1), .DEPTH(4)) u_a (
    .clk(clk), .rst(rst), .s(a_if), .blk_src(a_bsrc), .blk_shamt(a_bsh),
    .blk_dst(a_bdst), .occupancy(a_occ)
`ifdef UOP_STREAM_STATS_EN
    , .stat_issued(a_si), .stat_stall(a_ss)
`endif
  );
  uop_stream_ctrl #(.W(32), .LATENCY(2), .DEPTH(4)) u_b (
    .clk(clk), .rst(rst), .s(b_if), .blk_src(b_bsrc), .blk_shamt(b_bsh),
    .blk_dst(b_bdst), .occupancy(b_occ)
`ifdef UOP_STREAM_STATS_EN
    , .stat_issued(b_si), .stat_stall(b_ss)
`endif
  );
  uop_stream_ctrl #(.W(32), .LATENCY(0), .DEPTH(1)) u_c (
    .clk(clk), .rst(rst), .s(c_if), .blk_src(c_bsrc), .blk_shamt(c_bsh),
    .blk_dst(c_bdst), .occupancy(c_occ)
`ifdef UOP_STREAM_STATS_EN
    , .stat_issued(c_si), .stat_stall(c_ss)
`endif
  );
  uop_stream_ctrl #(.W(32), .LATENCY(1), .DEPTH(3)) u_d (
    .clk(clk), .rst(rst), .s(d_if), .blk_src(d_bsrc), .blk_shamt(d_bsh),
    .blk_dst(d_bdst), .occupancy(d_occ)
`ifdef UOP_STREAM_STATS_EN
    , .stat_issued(d_si), .stat_stall(d_ss)
`endif
  );
  uop_stream_ctrl #(.W(32), .LATENCY(3), .DEPTH(4)) u_e (
    .clk(clk), .rst(rst), .s(e_if), .blk_src(e_bsrc), .blk_shamt(e_bsh),
    .blk_dst(e_bdst), .occupancy(e_occ)
`ifdef UOP_STREAM_STATS_EN
    , .stat_issued(e_si), .stat_stall(e_ss)
`endif
  );
  uop_stream_ctrl #(.W(32), .LATENCY(1), .DEPTH(2)) u_f (
    .clk(clk), .rst(rst), .s(f_if), .blk_src(f_bsrc), .blk_shamt(f_bsh),
    .blk_dst(f_bdst), .occupancy(f_occ)
`ifdef UOP_STREAM_STATS_EN
    , .stat_issued(f_si), .stat_stall(f_ss)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    a_if.in_valid = 0; a_if.out_ready = 0; a_if.in_src = '0; a_if.in_shamt = '0;
    b_if.in_valid = 0; b_if.out_ready = 0; b_if.in_src = '0; b_if.in_shamt = '0;
    c_if.in_valid = 0; c_if.out_ready = 0; c_if.in_src = '0; c_if.in_shamt = '0;
    d_if.in_valid = 0; d_if.out_ready = 0; d_if.in_src = '0; d_if.in_shamt = '0;
    e_if.in_valid = 0; e_if.out_ready = 0; e_if.in_src = '0; e_if.in_shamt = '0;
    f_if.in_valid = 0; f_if.out_ready = 0; f_if.in_src = '0; f_if.in_shamt = '0;
  endtask

  task automatic do_reset();
    idle_all();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    idle_all();
    rst = 1'b1;
    step();
    step();
    n_cmp++;
    if (a_if.in_ready !== 1'b0) begin
      n_bad++; $display("FAIL reset_in_ready_low: got %b want 0", a_if.in_ready);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (a_if.in_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_in_ready_release: got %b want 1", a_if.in_ready);
    end
    n_cmp++;
    if (a_if.out_valid !== 1'b0 || a_occ !== 3'd0) begin
      n_bad++; $display("FAIL reset_a_state: out_valid %b occ %0d want 0 0", a_if.out_valid, a_occ);
    end
    n_cmp++;
    if (c_if.out_valid !== 1'b0 || c_occ !== 1'd0 || c_if.in_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_c_state: out_valid %b occ %0d in_ready %b want 0 0 1",
                        c_if.out_valid, c_occ, c_if.in_ready);
    end
    n_cmp++;
    if (e_if.out_valid !== 1'b0 || e_occ !== 3'd0) begin
      n_bad++; $display("FAIL reset_e_state: out_valid %b occ %0d want 0 0", e_if.out_valid, e_occ);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_q[$];
    int          iss_q[$];
    logic [31:0] exp;
    int          ic;
    int          got = 0;
    do_reset();
    a_if.out_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      if (a_if.out_valid === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++; $display("FAIL b2b_spurious: out_data %h with nothing expected", a_if.out_data);
        end else begin
          exp = exp_q.pop_front();
          ic  = iss_q.pop_front();
          got++;
          if (a_if.out_data !== exp || cyc != ic + 1) begin
            n_bad++; $display("FAIL b2b_result: got %h at cyc %0d want %h at cyc %0d",
                              a_if.out_data, cyc, exp, ic + 1);
          end
        end
      end
      if (i < 10) begin
        n_cmp++;
        if (a_if.in_ready !== 1'b1) begin
          n_bad++; $display("FAIL b2b_in_ready: got %b want 1 at op %0d", a_if.in_ready, i);
        end
        a_if.in_valid = 1'b1;
        a_if.in_src   = 32'h8000_0001 + 32'h0101_0101 * i;
        a_if.in_shamt = 5'(i);
        exp_q.push_back(rotl(a_if.in_src, a_if.in_shamt));
        iss_q.push_back(cyc + 1);
      end else begin
        a_if.in_valid = 1'b0;
      end
      step();
    end
    n_cmp++;
    if (got != 10) begin
      n_bad++; $display("FAIL b2b_count: got %0d results want 10", got);
    end
  endtask

  task automatic test_credit_stall();
    logic [31:0] exp_q[$];
    int          k = 0;
    do_reset();
    b_if.out_ready = 1'b0;
    b_if.in_valid  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      b_if.in_src   = 32'hB000_0000 + 32'h0001_0011 * k;
      b_if.in_shamt = 5'(k + 3);
      if (b_if.in_ready === 1'b1) begin
        exp_q.push_back(rotl(b_if.in_src, b_if.in_shamt));
        k++;
      end
      step();
    end
    n_cmp++;
    if (k != 4) begin
      n_bad++; $display("FAIL credit_accepted: got %0d want 4", k);
    end
    n_cmp++;
    if (b_if.in_ready !== 1'b0 || b_occ !== 3'd4) begin
      n_bad++; $display("FAIL credit_full: in_ready %b occ %0d want 0 4", b_if.in_ready, b_occ);
    end
    n_cmp++;
    if (b_if.out_valid !== 1'b1 || b_if.out_data !== exp_q[0]) begin
      n_bad++; $display("FAIL credit_head: valid %b data %h want 1 %h", b_if.out_valid, b_if.out_data, exp_q[0]);
    end
    b_if.out_ready = 1'b1;
    step();
    b_if.out_ready = 1'b0;
    void'(exp_q.pop_front());
    n_cmp++;
    if (b_if.in_ready !== 1'b1 || b_occ !== 3'd3) begin
      n_bad++; $display("FAIL credit_freed: in_ready %b occ %0d want 1 3", b_if.in_ready, b_occ);
    end
    n_cmp++;
    if (b_if.out_data !== exp_q[0]) begin
      n_bad++; $display("FAIL credit_next_head: got %h want %h", b_if.out_data, exp_q[0]);
    end
    b_if.in_src   = 32'hB000_0000 + 32'h0001_0011 * k;
    b_if.in_shamt = 5'(k + 3);
    exp_q.push_back(rotl(b_if.in_src, b_if.in_shamt));
    step();
    b_if.in_valid = 1'b0;
    n_cmp++;
    if (b_if.in_ready !== 1'b0 || b_occ !== 3'd4) begin
      n_bad++; $display("FAIL credit_refill: in_ready %b occ %0d want 0 4", b_if.in_ready, b_occ);
    end
    b_if.out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (b_if.out_valid === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++; $display("FAIL credit_drain_extra: got %h", b_if.out_data);
        end else if (b_if.out_data !== exp_q[0]) begin
          n_bad++; $display("FAIL credit_drain: got %h want %h", b_if.out_data, exp_q[0]);
          void'(exp_q.pop_front());
        end else begin
          void'(exp_q.pop_front());
        end
      end
      step();
    end
    n_cmp++;
    if (exp_q.size() != 0 || b_occ !== 3'd0) begin
      n_bad++; $display("FAIL credit_drain_end: left %0d occ %0d want 0 0", exp_q.size(), b_occ);
    end
  endtask

  task automatic test_depth1_l0();
    logic [31:0] last_exp = '0;
    logic        exp_rdy;
    do_reset();
    c_if.in_valid  = 1'b1;
    c_if.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      c_if.in_src   = 32'hC0DE_0000 + 32'(i);
      c_if.in_shamt = 5'(i + 1);
      #1;
      exp_rdy = ((i % 2) == 0);
      n_cmp++;
      if (c_bsrc !== c_if.in_src || c_bsh !== c_if.in_shamt) begin
        n_bad++; $display("FAIL l0_passthru: blk %h/%0d want %h/%0d", c_bsrc, c_bsh, c_if.in_src, c_if.in_shamt);
      end
      n_cmp++;
      if (c_if.in_ready !== exp_rdy || c_if.out_valid !== !exp_rdy) begin
        n_bad++; $display("FAIL l0_alternate: in_ready %b out_valid %b want %b %b at %0d",
                          c_if.in_ready, c_if.out_valid, exp_rdy, !exp_rdy, i);
      end
      if (!exp_rdy) begin
        n_cmp++;
        if (c_if.out_data !== last_exp) begin
          n_bad++; $display("FAIL l0_data: got %h want %h", c_if.out_data, last_exp);
        end
      end
      if (exp_rdy) last_exp = rotl(c_if.in_src, c_if.in_shamt);
      step();
    end
    c_if.in_valid = 1'b0;
  endtask

  task automatic test_wrap_d3();
    logic [31:0] exp_q[$];
    int          issued = 0;
    int          got    = 0;
    do_reset();
    for (int i = 0; i < 100 && got < 7; i++) begin
      d_if.out_ready = 1'($urandom_range(0, 1));
      if (issued < 7) begin
        d_if.in_valid = 1'b1;
        d_if.in_src   = 32'hD00D_0000 + 32'h0000_0303 * issued;
        d_if.in_shamt = 5'(issued * 5);
      end else begin
        d_if.in_valid = 1'b0;
      end
      if (d_if.out_valid === 1'b1 && d_if.out_ready === 1'b1) begin
        n_cmp++;
        got++;
        if (exp_q.size() == 0) begin
          n_bad++; $display("FAIL wrap_dup: got %h with nothing expected", d_if.out_data);
        end else if (d_if.out_data !== exp_q.pop_front()) begin
          n_bad++; $display("FAIL wrap_order: got %h at pop %0d", d_if.out_data, got);
        end
      end
      if (d_if.in_valid === 1'b1 && d_if.in_ready === 1'b1) begin
        exp_q.push_back(rotl(d_if.in_src, d_if.in_shamt));
        issued++;
      end
      step();
    end
    d_if.in_valid  = 1'b0;
    d_if.out_ready = 1'b0;
    n_cmp++;
    if (got != 7 || issued != 7) begin
      n_bad++; $display("FAIL wrap_count: popped %0d issued %0d want 7 7", got, issued);
    end
    n_cmp++;
    if (d_if.out_valid !== 1'b0 || d_occ !== 2'd0) begin
      n_bad++; $display("FAIL wrap_end: out_valid %b occ %0d want 0 0", d_if.out_valid, d_occ);
    end
  endtask

  task automatic test_reset_inflight();
    logic [31:0] exp;
    int          iss;
    bool_seen: begin end
    do_reset();
    e_if.out_ready = 1'b0;
    e_if.in_valid  = 1'b1;
    e_if.in_src    = 32'hE1E1_0001;
    e_if.in_shamt  = 5'd4;
    step();
    e_if.in_src    = 32'hE2E2_0002;
    e_if.in_shamt  = 5'd8;
    step();
    e_if.in_valid  = 1'b0;
    n_cmp++;
    if (e_occ !== 3'd2) begin
      n_bad++; $display("FAIL inflight_occ: got %0d want 2", e_occ);
    end
    step();
    // first operand's capture edge is the next one; reset lands on it
    rst = 1'b1;
    #1;
    n_cmp++;
    if (e_if.in_ready !== 1'b0) begin
      n_bad++; $display("FAIL inflight_rst_ready: got %b want 0", e_if.in_ready);
    end
    step();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (e_if.out_valid !== 1'b0 || e_occ !== 3'd0) begin
        n_bad++; $display("FAIL inflight_stale: out_valid %b occ %0d want 0 0 at %0d", e_if.out_valid, e_occ, i);
      end
      step();
    end
    e_if.in_valid = 1'b1;
    e_if.in_src   = 32'h0E3E_3E03;
    e_if.in_shamt = 5'd12;
    exp = rotl(e_if.in_src, e_if.in_shamt);
    iss = cyc + 1;
    step();
    e_if.in_valid = 1'b0;
    for (int i = 0; i < 8 && e_if.out_valid !== 1'b1; i++) step();
    n_cmp++;
    if (e_if.out_valid !== 1'b1 || e_if.out_data !== exp || cyc != iss + 3) begin
      n_bad++; $display("FAIL inflight_fresh: valid %b data %h cyc %0d want 1 %h %0d",
                        e_if.out_valid, e_if.out_data, cyc, exp, iss + 3);
    end
  endtask

`ifdef UOP_STREAM_STATS_EN
  task automatic test_stats();
    do_reset();
    n_cmp++;
    if (f_si !== 32'd0 || f_ss !== 32'd0) begin
      n_bad++; $display("FAIL stats_reset: issued %0d stall %0d want 0 0", f_si, f_ss);
    end
    f_if.out_ready = 1'b0;
    f_if.in_valid  = 1'b1;
    f_if.in_src    = 32'h0F0F_1234;
    f_if.in_shamt  = 5'd1;
    for (int i = 0; i < 6; i++) step();
    f_if.in_valid = 1'b0;
    n_cmp++;
    if (f_si !== 32'd2 || f_ss !== 32'd4) begin
      n_bad++; $display("FAIL stats_count: issued %0d stall %0d want 2 4", f_si, f_ss);
    end
    n_cmp++;
    if (f_occ !== 2'd2) begin
      n_bad++; $display("FAIL stats_occ: got %0d want 2", f_occ);
    end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    idle_all();
    test_reset();
    test_back_to_back();
    test_credit_stall();
    test_depth1_l0();
    test_wrap_d3();
    test_reset_inflight();
`ifdef UOP_STREAM_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
